// File: rtl/diamond_ctrl.sv
// Diamond placement sequencer for the snake game: samples random candidates, checks them
// against the snake body, publishes the accepted position, detects eats and times respawn.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | no game running, waiting for game_start
// SAMPLE   | latch candidate from x_rand/y_rand, raise occupancy query
// QUERY    | wait for occ_ack; accept, retry or fall back to fixed spot
// ACTIVE   | diamond drawn; hit-test the head on every frame_tick
// COOLDOWN | diamond eaten; count frames before the next placement

module diamond_ctrl #(
    parameter int COORD_W        = 12,
    parameter int DIAMOND_SIZE   = 10,
    parameter int MAX_RETRY      = 8,
    parameter int RESPAWN_FRAMES = 30,
    parameter int SCORE_W        = 8,
    parameter int FALLBACK_X     = 320,
    parameter int FALLBACK_Y     = 240
) (
    input  logic               vga_clk,
    input  logic               reset_n,
    input  logic               game_start,
    input  logic               game_over,
    input  logic               frame_tick,
    input  logic [COORD_W-1:0] head_x,
    input  logic [COORD_W-1:0] head_y,
    input  logic [COORD_W-1:0] x_rand,
    input  logic [COORD_W-1:0] y_rand,
    output logic               occ_req,
    output logic [COORD_W-1:0] occ_x,
    output logic [COORD_W-1:0] occ_y,
    input  logic               occ_ack,
    input  logic               occ_hit,
    output logic [COORD_W-1:0] diamond_x,
    output logic [COORD_W-1:0] diamond_y,
    output logic               diamond_valid,
    output logic               eaten,
    output logic [SCORE_W-1:0] score
);

    localparam int RW = $clog2(MAX_RETRY + 1);
    localparam int CW = (RESPAWN_FRAMES < 1) ? 1 : $clog2(RESPAWN_FRAMES + 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SAMPLE   = 3'd1,
        QUERY    = 3'd2,
        ACTIVE   = 3'd3,
        COOLDOWN = 3'd4
    } state_t;

    state_t             state;
    logic [RW-1:0]      retry_cnt;
    logic [CW-1:0]      cooldown;
    logic [COORD_W-1:0] cand_x;
    logic [COORD_W-1:0] cand_y;

    // One extra bit on the far edges so a diamond near the coordinate limit cannot wrap.
    logic [COORD_W:0] x_end;
    logic [COORD_W:0] y_end;
    logic             head_hit;

    assign x_end    = {1'b0, diamond_x} + (COORD_W + 1)'(DIAMOND_SIZE);
    assign y_end    = {1'b0, diamond_y} + (COORD_W + 1)'(DIAMOND_SIZE);
    assign head_hit = (head_x >= diamond_x) && ({1'b0, head_x} < x_end) &&
                      (head_y >= diamond_y) && ({1'b0, head_y} < y_end);

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            retry_cnt     <= '0;
            cooldown      <= '0;
            cand_x        <= '0;
            cand_y        <= '0;
            occ_req       <= 1'b0;
            occ_x         <= '0;
            occ_y         <= '0;
            diamond_x     <= '0;
            diamond_y     <= '0;
            diamond_valid <= 1'b0;
            eaten         <= 1'b0;
            score         <= '0;
        end else begin
            eaten <= 1'b0;
            if (game_over) begin
                state         <= IDLE;
                diamond_valid <= 1'b0;
                occ_req       <= 1'b0;
                retry_cnt     <= '0;
                cooldown      <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (game_start) begin
                            score     <= '0;
                            retry_cnt <= '0;
                            state     <= SAMPLE;
                        end
                    end
                    SAMPLE: begin
                        cand_x    <= x_rand;
                        cand_y    <= y_rand;
                        occ_x     <= x_rand;
                        occ_y     <= y_rand;
                        occ_req   <= 1'b1;
                        retry_cnt <= retry_cnt + RW'(1);
                        state     <= QUERY;
                    end
                    QUERY: begin
                        if (occ_req && occ_ack) begin
                            occ_req <= 1'b0;
                            if (!occ_hit) begin
                                diamond_x     <= cand_x;
                                diamond_y     <= cand_y;
                                diamond_valid <= 1'b1;
                                retry_cnt     <= '0;
                                state         <= ACTIVE;
                            end else if (retry_cnt < RW'(MAX_RETRY)) begin
                                state <= SAMPLE;
                            end else begin
                                diamond_x     <= COORD_W'(FALLBACK_X);
                                diamond_y     <= COORD_W'(FALLBACK_Y);
                                diamond_valid <= 1'b1;
                                retry_cnt     <= '0;
                                state         <= ACTIVE;
                            end
                        end
                    end
                    ACTIVE: begin
                        if (frame_tick && head_hit) begin
                            eaten         <= 1'b1;
                            diamond_valid <= 1'b0;
                            cooldown      <= CW'(RESPAWN_FRAMES);
                            state         <= COOLDOWN;
                            if (score != '1)
                                score <= score + SCORE_W'(1);
                        end
                    end
                    COOLDOWN: begin
                        if (cooldown == '0) begin
                            state <= SAMPLE;
                        end else if (frame_tick) begin
                            cooldown <= cooldown - CW'(1);
                            if (cooldown == CW'(1))
                                state <= SAMPLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_diamond_ctrl.sv
// Directed bench for diamond_ctrl: a scoreboard queue holds expected placements, checked when
// the diamond becomes valid; a second instance with zero respawn delay covers cooldown/saturation.

module tb_diamond_ctrl;

    localparam int CW = 12;

    logic          vga_clk = 1'b0;
    logic          reset_n, game_start, game_over, frame_tick;
    logic [CW-1:0] head_x, head_y, x_rand, y_rand;
    logic          occ_req, occ_ack, occ_hit;
    logic [CW-1:0] occ_x, occ_y, diamond_x, diamond_y;
    logic          diamond_valid, eaten;
    logic [7:0]    score;

    logic          occ_req_z, occ_ack_z, occ_hit_z;
    logic [CW-1:0] occ_x_z, occ_y_z, diamond_x_z, diamond_y_z;
    logic          diamond_valid_z, eaten_z;
    logic [7:0]    score_z;

    typedef struct packed {
        logic [CW-1:0] x;
        logic [CW-1:0] y;
    } pos_t;

    pos_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   exp_score = 0;

    always #5 vga_clk = ~vga_clk;

    // Second instance acknowledges its own queries immediately with no body overlap.
    assign occ_ack_z = occ_req_z;
    assign occ_hit_z = 1'b0;

    diamond_ctrl #(.RESPAWN_FRAMES(3)) dut (
        .vga_clk(vga_clk), .reset_n(reset_n), .game_start(game_start), .game_over(game_over),
        .frame_tick(frame_tick), .head_x(head_x), .head_y(head_y), .x_rand(x_rand), .y_rand(y_rand),
        .occ_req(occ_req), .occ_x(occ_x), .occ_y(occ_y), .occ_ack(occ_ack), .occ_hit(occ_hit),
        .diamond_x(diamond_x), .diamond_y(diamond_y), .diamond_valid(diamond_valid),
        .eaten(eaten), .score(score)
    );

    diamond_ctrl #(.RESPAWN_FRAMES(0)) dut_z (
        .vga_clk(vga_clk), .reset_n(reset_n), .game_start(game_start), .game_over(game_over),
        .frame_tick(frame_tick), .head_x(head_x), .head_y(head_y), .x_rand(x_rand), .y_rand(y_rand),
        .occ_req(occ_req_z), .occ_x(occ_x_z), .occ_y(occ_y_z), .occ_ack(occ_ack_z), .occ_hit(occ_hit_z),
        .diamond_x(diamond_x_z), .diamond_y(diamond_y_z), .diamond_valid(diamond_valid_z),
        .eaten(eaten_z), .score(score_z)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge vga_clk);
        #1;
    endtask

    function automatic logic [CW-1:0] sample_x(input int q);
        return CW'(212 - 16 * q);
    endfunction

    function automatic logic [CW-1:0] sample_y(input int q);
        return CW'(156 - 8 * q);
    endfunction

    task automatic wait_req();
        int n = 0;
        while (!occ_req && n < 50) begin
            step();
            n++;
        end
        check("wait_occ_req", occ_req, 1);
    endtask

    // Answers queries with hit=1 for the first n_hit of them, hit=0 afterwards.
    task automatic run_place(input int n_hit, output int nq);
        nq = 0;
        for (int q = 0; q < 10 && !diamond_valid; q++) begin
            wait_req();
            if (!occ_req) break;
            nq++;
            check("query_x", occ_x, sample_x(q));
            check("query_y", occ_y, sample_y(q));
            x_rand  = sample_x(q + 1);
            y_rand  = sample_y(q + 1);
            occ_ack = 1'b1;
            occ_hit = (q < n_hit);
            step();
            occ_ack = 1'b0;
            occ_hit = 1'b0;
            check("query_req_drop", occ_req, 0);
        end
    endtask

    task automatic check_placed();
        pos_t e;
        check("sb_not_empty", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("place_valid", diamond_valid, 1);
            check("place_x", diamond_x, e.x);
            check("place_y", diamond_y, e.y);
        end
    endtask

    task automatic tick_eat(input bit expect_eat);
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        check("eaten_pulse", eaten, expect_eat);
        if (expect_eat && exp_score < 255) exp_score++;
        check("score", score, exp_score);
        check("valid_after_tick", diamond_valid, !expect_eat);
        step();
        check("eaten_one_cycle", eaten, 0);
    endtask

    task automatic cooldown3();
        x_rand = sample_x(0);
        y_rand = sample_y(0);
        for (int k = 0; k < 3; k++) begin
            step(3);
            check("cooldown_no_req", occ_req, 0);
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
        end
        check("cooldown_sample", occ_req, 0);
        step();
        check("cooldown_req_after3", occ_req, 1);
    endtask

    initial begin
        int nq;
        int n;
        int eat_cnt;

        reset_n = 1'b0; game_start = 1'b0; game_over = 1'b0; frame_tick = 1'b0;
        occ_ack = 1'b0; occ_hit = 1'b0;
        head_x = 600; head_y = 470; x_rand = 0; y_rand = 0;
        step(2);
        check("rst_occ_req", occ_req, 0);
        check("rst_valid", diamond_valid, 0);
        check("rst_dx", diamond_x, 0);
        check("rst_occ_x", occ_x, 0);
        check("rst_eaten", eaten, 0);
        check("rst_score", score, 0);
        reset_n = 1'b1;
        step();

        // Start latency and first placement accepted on the first query.
        x_rand = 120; y_rand = 200;
        exp_q.push_back('{x: 12'd120, y: 12'd200});
        game_start = 1'b1;
        step();
        game_start = 1'b0;
        check("lat_sample_no_req", occ_req, 0);
        step();
        check("lat_req", occ_req, 1);
        check("lat_occ_x", occ_x, 120);
        check("lat_occ_y", occ_y, 200);
        check("lat_not_valid", diamond_valid, 0);
        occ_ack = 1'b1; occ_hit = 1'b0;
        step();
        occ_ack = 1'b0;
        check("lat_req_low", occ_req, 0);
        check_placed();
        check("score_start", score, 0);

        // Hit-box edges on (120,200).
        head_x = 130; head_y = 200;
        tick_eat(0);
        head_x = 129; head_y = 209;
        step(2);
        check("no_tick_no_eat", eaten, 0);
        check("no_tick_valid", diamond_valid, 1);
        tick_eat(1);

        // Seven rejected candidates, eighth accepted.
        cooldown3();
        exp_q.push_back('{x: sample_x(7), y: sample_y(7)});
        run_place(7, nq);
        check("retry7_queries", nq, 8);
        check_placed();

        head_x = 110; head_y = 100;
        tick_eat(0);
        head_x = 109; head_y = 109;
        step(2);
        check("no_tick_no_eat2", eaten, 0);
        tick_eat(1);

        // Every candidate rejected: fallback after MAX_RETRY queries.
        cooldown3();
        exp_q.push_back('{x: 12'd320, y: 12'd240});
        run_place(8, nq);
        check("fallback_queries", nq, 8);
        check_placed();
        step(10);
        check("no_9th_query", occ_req, 0);

        // game_over mid-query, then a late ack.
        head_x = 320; head_y = 240;
        tick_eat(1);
        cooldown3();
        game_over = 1'b1;
        step();
        check("go_req_low", occ_req, 0);
        check("go_valid_low", diamond_valid, 0);
        game_over = 1'b0;
        occ_ack = 1'b1; occ_hit = 1'b0;
        step();
        occ_ack = 1'b0;
        step();
        check("late_ack_valid", diamond_valid, 0);
        check("late_ack_req", occ_req, 0);
        check("go_score_held", score, exp_score);
        check("go_dx_held", diamond_x, 320);
        check("go_dy_held", diamond_y, 240);

        // game_over wins over game_start.
        game_start = 1'b1; game_over = 1'b1;
        step();
        game_start = 1'b0; game_over = 1'b0;
        step(2);
        check("start_over_idle", occ_req, 0);
        check("start_over_score", score, exp_score);

        // Zero respawn delay on the second instance.
        x_rand = 50; y_rand = 60; head_x = 50; head_y = 60;
        game_start = 1'b1;
        step();
        game_start = 1'b0;
        step();
        check("z_req", occ_req_z, 1);
        check("z_score_clear", score_z, 0);
        step();
        check("z_valid", diamond_valid_z, 1);
        check("z_dx", diamond_x_z, 50);
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        check("z_eaten", eaten_z, 1);
        check("z_score1", score_z, 1);
        check("z_valid_low", diamond_valid_z, 0);
        step();
        check("z_sample_no_req", occ_req_z, 0);
        step();
        check("z_req_again", occ_req_z, 1);

        // Keep eating until the score saturates.
        frame_tick = 1'b1;
        n = 0;
        while (score_z != 8'd255 && n < 3000) begin
            step();
            n++;
        end
        check("z_score_reach255", score_z, 255);
        eat_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (eaten_z) eat_cnt++;
        end
        frame_tick = 1'b0;
        check("z_eats_after_255", eat_cnt > 0, 1);
        check("z_score_sat", score_z, 255);

        // Asynchronous reset while the main instance waits on a query.
        check("pre_reset_req", occ_req, 1);
        reset_n = 1'b0;
        #2;
        check("async_rst_req", occ_req, 0);
        check("async_rst_score", score, 0);
        reset_n = 1'b1;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/diamond_ctrl.md
Name: diamond_ctrl

Overview:
- Sequences diamond placement for the snake game.
- Samples candidate coordinates from the pseudo-random diamond position generator (x_rand/y_rand).
- Validates each candidate against snake-body occupancy through a request/acknowledge query; retries a bounded number of times, then falls back to a fixed position.
- Publishes the accepted position to the renderer, detects head-on-diamond per frame, counts score and times the respawn delay.

Parameters:
- COORD_W, 12, width of all pixel coordinates.
- DIAMOND_SIZE, 10, diamond edge length in pixels (square hit box).
- MAX_RETRY, 8, max candidate samples per placement before fallback (>=1).
- RESPAWN_FRAMES, 30, frames between eat and next placement attempt (0 allowed).
- SCORE_W, 8, score counter width.
- FALLBACK_X, 320, x used when retries are exhausted.
- FALLBACK_Y, 240, y used when retries are exhausted.

Ports:
- vga_clk  in  1  31.5 MHz pixel clock; all state on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- game_start  in  1  one-cycle pulse; starts a game from IDLE.
- game_over  in  1  level; forces IDLE while high.
- frame_tick  in  1  one-cycle pulse per frame.
- head_x / head_y  in  COORD_W each  snake head top-left pixel.
- x_rand / y_rand  in  COORD_W each  generator outputs, change every cycle.
- occ_req  out  1  occupancy query valid.
- occ_x / occ_y  out  COORD_W each  candidate under query.
- occ_ack  in  1  query response strobe.
- occ_hit  in  1  candidate overlaps body; valid only with occ_ack.
- diamond_x / diamond_y  out  COORD_W each  published position.
- diamond_valid  out  1  diamond drawn and collidable.
- eaten  out  1  one-cycle pulse on eat.
- score  out  SCORE_W  diamonds eaten this game.

Behaviour:
- Reset (async, reset_n=0): state IDLE; all outputs 0 (diamond_x/y=0, valid=0, occ_req=0, occ_x/y=0, eaten=0, score=0); retry and cooldown counters cleared.
- States: IDLE, SAMPLE, QUERY, ACTIVE, COOLDOWN. All outputs registered.
- IDLE:
  - game_start=1 -> SAMPLE; score cleared to 0.
  - game_start outside IDLE is ignored.
- SAMPLE (1 cycle):
  - cand_x/cand_y <= x_rand/y_rand; retry_cnt += 1.
  - -> QUERY, with occ_req=1 and occ_x/y=cand visible from the next cycle.
- QUERY:
  - occ_req, occ_x and occ_y are held stable until occ_ack is sampled high.
  - occ_ack=1, occ_hit=0 -> diamond_x/y <= cand; diamond_valid <= 1; occ_req <= 0; retry_cnt <= 0; -> ACTIVE.
  - occ_ack=1, occ_hit=1, retry_cnt<MAX_RETRY -> occ_req <= 0; -> SAMPLE.
  - occ_ack=1, occ_hit=1, retry_cnt==MAX_RETRY -> diamond_x/y <= FALLBACK_X/Y; valid <= 1; retry_cnt <= 0; -> ACTIVE.
  - No timeout; the query waits for occ_ack indefinitely.
- Latency: game_start at edge N gives SAMPLE during N+1 and occ_req high after N+2. With occ_ack at the first QUERY cycle, diamond_valid is high after edge N+3.
- ACTIVE:
  - Evaluated only when frame_tick=1.
  - Hit test: head_x >= diamond_x && head_x < diamond_x+DIAMOND_SIZE && head_y >= diamond_y && head_y < diamond_y+DIAMOND_SIZE.
  - Sums are computed at COORD_W+1 bits, so there is no wrap near the coordinate limit.
  - On hit: eaten=1 for exactly one cycle; score += 1, saturating at all-ones; diamond_valid <= 0; cooldown <= RESPAWN_FRAMES; -> COOLDOWN.
  - diamond_x/y keep their last value while invalid.
- COOLDOWN:
  - If cooldown==0, go to SAMPLE next cycle (covers RESPAWN_FRAMES=0).
  - Otherwise decrement on each frame_tick; the tick that takes the count 1->0 also moves to SAMPLE.
- game_over=1, any state:
  - Next state IDLE; diamond_valid <= 0; occ_req <= 0; eaten <= 0.
  - score and diamond_x/y are held, not cleared.
  - game_over overrides game_start in the same cycle.
  - A pending query is abandoned, and a later occ_ack in IDLE is ignored.
- occ_ack while occ_req=0 is ignored in every state.
- Reset mid-query drops occ_req immediately (asynchronous clear).

Test Plan:
- Reset then game_start; occ_ack with hit=0 at the first QUERY cycle; x_rand=120, y_rand=200 at SAMPLE -> diamond_valid high after edge N+3, diamond_x=120, diamond_y=200, occ_req deasserted after edge N+3.
- Occupancy responder returns hit=1 on 7 consecutive queries, then hit=0 -> exactly 8 occ_req assertions; accepted position equals the 8th sample.
- Responder always returns hit=1, MAX_RETRY=8 -> 8 queries, then diamond_x=320, diamond_y=240, valid=1, no 9th query.
- Diamond at (100,100); head (109,109) on frame_tick -> eaten 1 cycle, score 0->1, valid=0. Repeat with head (110,100) -> no eat. Head moving onto the diamond without frame_tick -> no eat.
- RESPAWN_FRAMES=3 after an eat -> next occ_req appears only after the 3rd frame_tick. With RESPAWN_FRAMES=0 -> SAMPLE the cycle after COOLDOWN entry.
- Extra cases:
  - game_over asserted mid-QUERY -> occ_req low next cycle; a late occ_ack does not change diamond_valid.
  - game_start and game_over together -> stays IDLE.
  - Score at 255 with SCORE_W=8 plus one eat -> stays 255.
